// File: rtl/rtc_bus_pkg.sv
// Shared types and default chip-cycle timing for the RTC bus sequencer.
package rtc_bus_pkg;

  localparam int T_SU  = 2;
  localparam int T_STB = 8;
  localparam int T_HD  = 2;
  localparam int T_GAP = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_SU,
    ST_ADDR_STB,
    ST_ADDR_HD,
    ST_DATA_SU,
    ST_DATA_STB,
    ST_DATA_HD,
    ST_GAP
  } state_t;

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// Host request/response and multiplexed RTC chip bus grouped into one bundle.
interface rtc_bus_sequencer_if;
  logic       start;
  logic       rw;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] ad_in;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       ad_n;

  modport master (
    output start, rw, addr, wdata, ad_in,
    input  busy, done, rdata, ad_out, ad_oe, cs_n, rd_n, wr_n, ad_n
  );

  modport slave (
    input  start, rw, addr, wdata, ad_in,
    output busy, done, rdata, ad_out, ad_oe, cs_n, rd_n, wr_n, ad_n
  );
endinterface

// File: rtl/bus_phase_timer.sv
// Loadable down-counter that parks at zero; a load always wins over counting.
module bus_phase_timer #(
  parameter int W = 4
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Two-phase (address, then data) RTC chip bus cycle engine, one transaction per start.
//   state       | meaning
//   IDLE        | bus released, waiting for start
//   ADDR_SU     | address driven, ad_n=0, before write strobe
//   ADDR_STB    | wr_n low latching the address
//   ADDR_HD     | address held after strobe
//   DATA_SU     | ad_n=1, write data driven or bus released for read
//   DATA_STB    | wr_n or rd_n low; read data captured on last cycle
//   DATA_HD     | strobes high, cs_n still low
//   GAP         | cs_n high between transactions, done on last cycle
module rtc_bus_sequencer #(
  parameter int T_SU  = rtc_bus_pkg::T_SU,
  parameter int T_STB = rtc_bus_pkg::T_STB,
  parameter int T_HD  = rtc_bus_pkg::T_HD,
  parameter int T_GAP = rtc_bus_pkg::T_GAP
) (
  input logic                i_clock,
  input logic                i_reset,
  rtc_bus_sequencer_if.slave bus
);
  import rtc_bus_pkg::*;

  localparam int T_M1  = (T_SU > T_STB) ? T_SU : T_STB;
  localparam int T_M2  = (T_HD > T_GAP) ? T_HD : T_GAP;
  localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int CNT_W = $clog2(T_MAX) + 1;

  localparam logic [CNT_W-1:0] L_SU  = CNT_W'(T_SU - 1);
  localparam logic [CNT_W-1:0] L_STB = CNT_W'(T_STB - 1);
  localparam logic [CNT_W-1:0] L_HD  = CNT_W'(T_HD - 1);
  localparam logic [CNT_W-1:0] L_GAP = CNT_W'(T_GAP - 1);

  state_t           r_state, w_nxt_state;
  logic             r_rw;
  logic [7:0]       r_addr, r_wdata;
  logic             w_load, w_zero;
  logic [CNT_W-1:0] w_load_val, w_count, w_cnt_nxt;
  logic             w_rw_sel;
  logic [7:0]       w_addr_sel, w_wdata_sel;

  logic       r_busy, r_done, r_ad_oe, r_cs_n, r_rd_n, r_wr_n, r_ad_n;
  logic [7:0] r_rdata, r_ad_out;
  logic       w_busy, w_done, w_ad_oe, w_cs_n, w_rd_n, w_wr_n, w_ad_n, w_cap;
  logic [7:0] w_ad_out;

  bus_phase_timer #(.W(CNT_W)) u_timer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_count    (w_count),
    .o_zero     (w_zero)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    case (r_state)
      ST_IDLE:     if (bus.start) w_nxt_state = ST_ADDR_SU;
      ST_ADDR_SU:  if (w_zero) w_nxt_state = ST_ADDR_STB;
      ST_ADDR_STB: if (w_zero) w_nxt_state = ST_ADDR_HD;
      ST_ADDR_HD:  if (w_zero) w_nxt_state = ST_DATA_SU;
      ST_DATA_SU:  if (w_zero) w_nxt_state = ST_DATA_STB;
      ST_DATA_STB: if (w_zero) w_nxt_state = ST_DATA_HD;
      ST_DATA_HD:  if (w_zero) w_nxt_state = ST_GAP;
      ST_GAP:      if (w_zero) w_nxt_state = ST_IDLE;
      default:     w_nxt_state = ST_IDLE;
    endcase
    if (w_nxt_state != r_state) begin
      w_load = 1'b1;
      case (w_nxt_state)
        ST_ADDR_SU, ST_DATA_SU:   w_load_val = L_SU;
        ST_ADDR_STB, ST_DATA_STB: w_load_val = L_STB;
        ST_ADDR_HD, ST_DATA_HD:   w_load_val = L_HD;
        ST_GAP:                   w_load_val = L_GAP;
        default:                  w_load_val = '0;
      endcase
    end
    w_cnt_nxt = w_load ? w_load_val : (w_zero ? '0 : w_count - 1'b1);
  end

  // Outputs are registered from the next state, so the launch cycle must use live inputs.
  assign w_rw_sel    = (r_state == ST_IDLE) ? bus.rw    : r_rw;
  assign w_addr_sel  = (r_state == ST_IDLE) ? bus.addr  : r_addr;
  assign w_wdata_sel = (r_state == ST_IDLE) ? bus.wdata : r_wdata;
  assign w_cap       = (r_state == ST_DATA_STB) && w_zero && r_rw;

  always_comb begin
    w_busy   = (w_nxt_state != ST_IDLE);
    w_done   = (w_nxt_state == ST_GAP) && (w_cnt_nxt == '0);
    w_cs_n   = 1'b1;
    w_rd_n   = 1'b1;
    w_wr_n   = 1'b1;
    w_ad_n   = 1'b1;
    w_ad_oe  = 1'b0;
    w_ad_out = 8'h00;
    case (w_nxt_state)
      ST_ADDR_SU, ST_ADDR_STB, ST_ADDR_HD: begin
        w_cs_n   = 1'b0;
        w_ad_n   = 1'b0;
        w_ad_oe  = 1'b1;
        w_ad_out = w_addr_sel;
        w_wr_n   = (w_nxt_state != ST_ADDR_STB);
      end
      ST_DATA_SU, ST_DATA_STB, ST_DATA_HD: begin
        w_cs_n = 1'b0;
        if (!w_rw_sel) begin
          w_ad_oe  = 1'b1;
          w_ad_out = w_wdata_sel;
          w_wr_n   = (w_nxt_state != ST_DATA_STB);
        end else begin
          w_rd_n = (w_nxt_state != ST_DATA_STB);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state  <= ST_IDLE;
      r_rw     <= 1'b0;
      r_addr   <= 8'h00;
      r_wdata  <= 8'h00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rdata  <= 8'h00;
      r_ad_out <= 8'h00;
      r_ad_oe  <= 1'b0;
      r_cs_n   <= 1'b1;
      r_rd_n   <= 1'b1;
      r_wr_n   <= 1'b1;
      r_ad_n   <= 1'b1;
    end else begin
      r_state <= w_nxt_state;
      if (r_state == ST_IDLE && bus.start) begin
        r_rw    <= bus.rw;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
      end
      if (w_cap) r_rdata <= bus.ad_in;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_ad_out <= w_ad_out;
      r_ad_oe  <= w_ad_oe;
      r_cs_n   <= w_cs_n;
      r_rd_n   <= w_rd_n;
      r_wr_n   <= w_wr_n;
      r_ad_n   <= w_ad_n;
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.rdata  = r_rdata;
  assign bus.ad_out = r_ad_out;
  assign bus.ad_oe  = r_ad_oe;
  assign bus.cs_n   = r_cs_n;
  assign bus.rd_n   = r_rd_n;
  assign bus.wr_n   = r_wr_n;
  assign bus.ad_n   = r_ad_n;

endmodule
